serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Time-shares one full_adder cell across WIDTH bit positions, one bit per clock, LSB first.
- Latches two WIDTH-bit operands and a carry-in on a start pulse.
- Sequences the cell through a carry register, assembles the sum and carry-out, then signals completion with a one-cycle done pulse.
- Sits between a requester issuing add operations and the shared 1-bit adder datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits (legal range 2..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a new add; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: sum/cout valid.
- sum  output  WIDTH  result; held until next accepted start.
- cout  output  1  final carry-out; held with sum.

Behaviour:
- Reset: asynchronous assert, synchronous release. busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, state=IDLE.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> load shift registers a_sh=a, b_sh=b, carry register=cin; counter=0; go to RUN. start=0 -> stay.
- RUN, each cycle:
  - Drive full_adder with A=a_sh[0], B=b_sh[0], carry=carry register.
  - Shift sum register right, inserting the adder's sum at the MSB.
  - Shift a_sh and b_sh right by one.
  - Carry register <= carryout; counter += 1.
  - When counter reaches WIDTH-1 (processing the last bit): cout <= carryout, go to DONE.
  - start is ignored in RUN; operands are not re-sampled.
- DONE: done=1 for exactly this cycle; busy=0.
  - start=1 -> accept as in IDLE and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.
- Latency: start accepted at edge 0. busy=1 for cycles 1..WIDTH; done=1 during cycle WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- sum and cout are only updated in RUN. Between done and the next accepted start they hold the final result.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH; cout = bit WIDTH of the full sum. Operands are unsigned.
- Reset mid-RUN: the operation is abandoned, all outputs return to reset values, and no done pulse is produced.
- Input changes on a, b, cin after acceptance have no effect on the result.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit).
  - ovf = carry into the MSB XOR carry out of the MSB, i.e. two's-complement signed overflow.
  - ovf is captured on the last RUN cycle alongside cout, reset to 0, and held with sum.
- When undefined: the ovf port and its register are absent; the rest of the behaviour is unchanged.

Decomposition:
- Shared package: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus default WIDTH.
- Sub-module: instantiate the existing full_adder cell (ports A, B, carry, sum, carryout) as the single datapath element. It is pure combinational; no other sub-module.

Test Plan (WIDTH=8):
- a=8'h0F, b=8'h01, cin=0, start pulse -> busy high 8 cycles, done 9 cycles after start; sum=8'h10, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, cout=1.
- Hold start=1 continuously with a=8'h12, b=8'h34 -> back-to-back results 8'h46 every 9 cycles. Operand change to a=8'hAA mid-RUN does not affect the current result.
- start pulsed at the 3rd RUN cycle with a=8'h55 -> ignored; only one done, with the original result.
- rst_n low at the 4th RUN cycle -> busy=0, done=0, sum=8'h00, cout=0 immediately; no done pulse after release.
- With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1. a=8'h80, b=8'h80 -> sum=8'h00, cout=1, ovf=1. a=8'hFF, b=8'h01 -> ovf=0.

Source files
------------

// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Contents: FSM state encoding and the default operand width.
// No logic; imported by the interface and the controller top.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between an add requester and serial_add_ctrl.
// Latency: n/a (wires only). Backpressure: none; start is only honoured when the controller is not busy.
// Ports: start/a/b/cin (requester -> controller), busy/done/sum/cout[/ovf] (controller -> requester).
// ovf exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  // Requester side.
  modport master (
    output start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  busy, done, sum, cout
  );

  // Controller side.
  modport slave (
    input  start, a, b, cin,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output busy, done, sum, cout
  );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell, the single shared datapath element.
// Latency: purely combinational. Backpressure: none.
// Ports: A, B, carry in; sum, carryout out.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic carry,
  output logic sum,
  output logic carryout
);

  assign sum      = A ^ B ^ carry;
  assign carryout = (A & B) | (carry & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: time-shares one full_adder across WIDTH bits, LSB first.
// Latency: start accepted at edge 0, busy for cycles 1..WIDTH, done pulse in cycle WIDTH+1.
// Backpressure: start is ignored while busy; a start during the done cycle chains back-to-back.
// Ports: clk, rst_n (async active-low), bus (serial_add_ctrl_if.slave; WIDTH must match).
// Optional: define SERIAL_ADD_OVF_EN to add the registered signed-overflow flag bus.ovf.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
)(
  input  logic            clk,
  input  logic            rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_r;
  logic [CNT_W-1:0] cnt;
  logic             carry_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;
  logic             fa_sum;
  logic             fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_r;
`endif

  // Operand bit 0 of the shift registers is always the bit being processed.
  full_adder u_fa (
    .A        (a_sh[0]),
    .B        (b_sh[0]),
    .carry    (carry_r),
    .sum      (fa_sum),
    .carryout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_r   <= '0;
      cnt     <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_r   <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE so requests can chain.
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh    <= bus.a;
            b_sh    <= bus.b;
            carry_r <= bus.cin;
            cnt     <= '0;
            busy_r  <= 1'b1;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end

        S_RUN: begin
          // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands at sum[0].
          sum_r   <= {fa_sum, sum_r[WIDTH-1:1]};
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_r <= fa_cout;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            cout_r <= fa_cout;
`ifdef SERIAL_ADD_OVF_EN
            // carry_r is the carry into the MSB on this cycle.
            ovf_r  <= carry_r ^ fa_cout;
`endif
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end

        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// Overflow checks are active only when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  serial_add_ctrl_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One isolated add; checks busy length, done timing, result and hold.
  task automatic do_add(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic [7:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf);
    int busy_cnt;
    int waited;
    @(negedge clk);
    bus.start = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt = 0;
    waited   = 0;
    while (!bus.done && waited < 20) begin
      if (bus.busy) busy_cnt++;
      waited++;
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_lat"}, 32'(waited), 32'd8);
    chk({tag, "_busycnt"}, 32'(busy_cnt), 32'd8);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) n_chk = n_chk;
`endif
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    chk({tag, "_hold"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  initial begin
    int t;
    int ndone;
    int first_t;
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    do_add("add0f01",   8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    do_add("addff01",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_add("addff00c",  8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add("adda55ac",  8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    do_add("add7f01",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_add("add8080",   8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Back-to-back with start held; operand A changes during the second run.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    t = 0; ndone = 0; first_t = 0;
    while (ndone < 2 && t < 40) begin
      @(negedge clk);
      t++;
      if (t == 12) bus.a = 8'hAA;
      if (bus.done) begin
        ndone++;
        chk("b2b_sum", 32'(bus.sum), 32'h46);
        chk("b2b_busy_at_done", 32'(bus.busy), 32'd0);
        if (ndone == 1) begin
          first_t = t;
          chk("b2b_first_t", 32'(t), 32'd9);
        end else begin
          chk("b2b_gap", 32'(t - first_t), 32'd9);
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("b2b_ndone", 32'(ndone), 32'd2);
    @(negedge clk);
    chk("b2b_idle_busy", 32'(bus.busy), 32'd0);

    // Start pulsed during RUN must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h20; bus.b = 8'h03; bus.cin = 1'b0;
    t = 0; ndone = 0; first_t = 0;
    while (t < 25) begin
      @(negedge clk);
      t++;
      if (t == 1) bus.start = 1'b0;
      if (t == 3) begin bus.start = 1'b1; bus.a = 8'h55; end
      if (t == 4) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        first_t = t;
        chk("ign_sum", 32'(bus.sum), 32'h23);
      end
    end
    chk("ign_ndone", 32'(ndone), 32'd1);
    chk("ign_t", 32'(first_t), 32'd9);

    // Reset asserted in the 4th RUN cycle abandons the add.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h0F; bus.b = 8'h01; bus.cin = 1'b1;
    repeat (4) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("mid_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_done", 32'(bus.done), 32'd0);
    chk("mid_rst_sum", 32'(bus.sum), 32'd0);
    chk("mid_rst_cout", 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done || bus.busy) ndone++;
    end
    chk("mid_rst_no_done", 32'(ndone), 32'd0);
    chk("mid_rst_sum_after", 32'(bus.sum), 32'd0);

    // Controller still usable after the abandoned add.
    do_add("post_rst", 8'h33, 8'h44, 1'b1, 8'h78, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
